// File: rtl/fft_pkg.sv
// Shared constants and FSM state type for the double-adder request arbiter.
package fft_pkg;
  localparam int NREQ = 4;
  localparam int W    = 64;
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_Z,
    RESP
  } state_t;
endpackage

// File: rtl/fp_add_arbiter_if.sv
// Requester, adder and response signals shared between the arbiter and its environment.
interface fp_add_arbiter_if #(
  parameter int NREQ = fft_pkg::NREQ,
  parameter int W    = fft_pkg::W
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_ready;

  logic [W-1:0]      add_a;
  logic [W-1:0]      add_b;
  logic              add_a_stb;
  logic              add_b_stb;
  logic              add_a_ack;
  logic              add_b_ack;
  logic [W-1:0]      add_z;
  logic              add_z_stb;
  logic              add_z_ack;

  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_data;
  logic              rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, add_a_ack, add_b_ack, add_z, add_z_stb, rsp_ready,
    output req_ready, add_a, add_b, add_a_stb, add_b_stb, add_z_ack, rsp_valid, rsp_id, rsp_data
  );

  modport master (
    output req_valid, req_a, req_b, add_a_ack, add_b_ack, add_z, add_z_stb, rsp_ready,
    input  req_ready, add_a, add_b, add_a_stb, add_b_stb, add_z_ack, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = fft_pkg::NREQ,
  parameter int IDW  = fft_pkg::IDW
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);
  import fft_pkg::*;

  always_comb begin
    logic           hit;
    logic [IDW-1:0] j;
    hit   = 1'b0;
    j     = '0;
    grant = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = IDW'((32'(ptr) + k) % 32'(NREQ));
      if (!hit && req[j]) begin
        hit      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one double_adder among NREQ requesters; one addition in flight at a time.
module fp_add_arbiter #(
  parameter int NREQ = fft_pkg::NREQ,
  parameter int W    = fft_pkg::W
) (
  input logic             clk,
  input logic             reset,
  fp_add_arbiter_if.slave bus
);
  import fft_pkg::*;

  localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] next_ptr;
  logic [NREQ-1:0] gnt;
  logic [W-1:0]    sel_a;
  logic [W-1:0]    sel_b;

  rr_arbiter #(.NREQ(NREQ), .IDW(ID_W)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_a = bus.req_a[k*W +: W];
        sel_b = bus.req_b[k*W +: W];
      end
    end
  end

  assign next_ptr = (gnt_idx == ID_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Grant pulse is combinational; held low while reset is asserted.
  always_comb begin
    bus.req_ready = '0;
    if (state == IDLE && !reset) bus.req_ready = gnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      bus.add_a     <= '0;
      bus.add_b     <= '0;
      bus.add_a_stb <= 1'b0;
      bus.add_b_stb <= 1'b0;
      bus.add_z_ack <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= '0;
      bus.rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            bus.add_a     <= sel_a;
            bus.add_b     <= sel_b;
            bus.rsp_id    <= gnt_idx;
            rr_ptr        <= next_ptr;
            bus.add_a_stb <= 1'b1;
            bus.add_b_stb <= 1'b1;
            state         <= SEND;
          end
        end
        SEND: begin
          // Each operand strobe retires on its own ack; leave once neither is pending.
          if (bus.add_a_ack) bus.add_a_stb <= 1'b0;
          if (bus.add_b_ack) bus.add_b_stb <= 1'b0;
          if ((!bus.add_a_stb || bus.add_a_ack) && (!bus.add_b_stb || bus.add_b_ack)) begin
            bus.add_z_ack <= 1'b1;
            state         <= WAIT_Z;
          end
        end
        WAIT_Z: begin
          if (bus.add_z_stb) begin
            bus.rsp_data  <= bus.add_z;
            bus.add_z_ack <= 1'b0;
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: behavioural adder stub, requesters and a transaction-level reference model.
module tb_fp_add_arbiter;
  localparam int N   = fft_pkg::NREQ;
  localparam int WD  = fft_pkg::W;
  localparam int IDT = (N > 1) ? $clog2(N) : 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NREQ(N), .W(WD)) bus ();
  fp_add_arbiter #(.NREQ(N), .W(WD)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [N-1:0]  vld;
  logic [WD-1:0] opa [N];
  logic [WD-1:0] opb [N];
  bit cont, rnd_req, rnd_dly;

  int a_dly, b_dly, z_dly, r_dly;
  int a_cnt, b_cnt, z_cnt, r_cnt;
  logic [WD-1:0] a_cap, b_cap;
  bit a_got, b_got;

  int m_ptr;
  bit m_busy;
  int exp_id;
  logic [WD-1:0] exp_a, exp_b, exp_sum;
  int g_cyc, a_hi, b_hi, z_hi, z_rises, z_hs_n, r_hi, lat;
  bit z_prev, rsp_seen;
  int n_rsp;
  int last_id, last_lat, last_a_hi, last_b_hi, last_z_hi, last_z_rises, last_z_hs, last_r_hi;
  logic [WD-1:0] last_data;
  int gnt_log[$];

  function automatic logic [WD-1:0] fadd(input logic [WD-1:0] a, input logic [WD-1:0] b);
    return $realtobits($bitstoreal(a) + $bitstoreal(b));
  endfunction

  function automatic logic [WD-1:0] rnd_op();
    int v;
    v = int'($urandom_range(0, 2000000)) - 1000000;
    return $realtobits(real'(v) / 1024.0);
  endfunction

  // Requester chosen by the rotating-priority rule.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int d = 0; d < N; d++) if (v[(p + d) % N]) return (p + d) % N;
    return -1;
  endfunction

  task automatic drive_inputs();
    bus.req_valid = vld;
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*WD +: WD] = opa[i];
      bus.req_b[i*WD +: WD] = opb[i];
    end
    bus.add_a_ack = bus.add_a_stb && (a_cnt >= a_dly);
    bus.add_b_ack = bus.add_b_stb && (b_cnt >= b_dly);
    bus.add_z_stb = bus.add_z_ack && (z_cnt >= z_dly);
    bus.add_z     = (a_got && b_got) ? fadd(a_cap, b_cap) : '0;
    bus.rsp_ready = bus.rsp_valid && (r_cnt >= r_dly);
  endtask

  task automatic clear_model();
    m_ptr = 0; m_busy = 0;
    a_cnt = 0; b_cnt = 0; z_cnt = 0; r_cnt = 0;
    a_got = 0; b_got = 0; z_prev = 0; rsp_seen = 0;
    a_hi = 0; b_hi = 0; z_hi = 0; z_rises = 0; z_hs_n = 0; r_hi = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_model();
    gnt_log.delete();
    bus.add_a_ack = 1'b0; bus.add_b_ack = 1'b0;
    bus.add_z_stb = 1'b0; bus.rsp_ready = 1'b0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step();
    logic [N-1:0] eg;
    int gi, cur, mx;
    bit av, bv, zv, rv, a_hs, b_hs, z_hs, r_hs;
    cur = cyc;
    drive_inputs();
    #1;
    gi = m_busy ? -1 : pick(vld, m_ptr);
    eg = '0;
    if (gi >= 0) eg[gi] = 1'b1;
    n_cmp++;
    if (bus.req_ready !== eg) begin
      n_err++;
      $display("FAIL req_ready cyc=%0d got=%b want=%b", cur, bus.req_ready, eg);
    end
    av = bus.add_a_stb; bv = bus.add_b_stb; zv = bus.add_z_ack; rv = bus.rsp_valid;
    a_hs = av && bus.add_a_ack; b_hs = bv && bus.add_b_ack;
    z_hs = zv && bus.add_z_stb; r_hs = rv && bus.rsp_ready;
    if (!m_busy) begin
      n_cmp++;
      if ({av, bv, zv, rv} !== 4'b0000) begin
        n_err++;
        $display("FAIL idle_outputs cyc=%0d got stb_a/stb_b/z_ack/rsp_valid=%b want 0000", cur, {av, bv, zv, rv});
      end
    end else begin
      if (av || bv) begin
        n_cmp++;
        if (bus.add_a !== exp_a || bus.add_b !== exp_b || zv || rv) begin
          n_err++;
          $display("FAIL send_operands cyc=%0d got a=%h b=%h z_ack=%b rv=%b want a=%h b=%h 0 0",
                   cur, bus.add_a, bus.add_b, zv, rv, exp_a, exp_b);
        end
      end
      if (rv) begin
        n_cmp++;
        if (bus.rsp_id !== IDT'(exp_id) || bus.rsp_data !== exp_sum || zv) begin
          n_err++;
          $display("FAIL rsp_payload cyc=%0d got id=%0d data=%h z_ack=%b want id=%0d data=%h 0",
                   cur, bus.rsp_id, bus.rsp_data, zv, exp_id, exp_sum);
        end
      end
    end
    if (a_hs) begin a_cap = bus.add_a; a_got = 1; end
    if (b_hs) begin b_cap = bus.add_b; b_got = 1; end
    if (av) a_hi++;
    if (bv) b_hi++;
    if (zv) z_hi++;
    if (zv && !z_prev) z_rises++;
    if (z_hs) z_hs_n++;
    if (rv) r_hi++;
    if (rv && !rsp_seen) begin rsp_seen = 1; lat = cur - g_cyc; end
    z_prev = zv;
    if (r_hs) begin
      mx = (a_dly > b_dly) ? a_dly : b_dly;
      n_cmp++;
      if (lat != (mx + 1) + (z_dly + 1) + 1 || a_hi != a_dly + 1 || b_hi != b_dly + 1 ||
          z_hi != z_dly + 1 || z_rises != 1 || z_hs_n != 1 || r_hi != r_dly + 1) begin
        n_err++;
        $display("FAIL txn_timing id=%0d got lat=%0d a=%0d b=%0d z=%0d zr=%0d zh=%0d r=%0d want lat=%0d a=%0d b=%0d z=%0d 1 1 r=%0d",
                 exp_id, lat, a_hi, b_hi, z_hi, z_rises, z_hs_n, r_hi,
                 mx + z_dly + 3, a_dly + 1, b_dly + 1, z_dly + 1, r_dly + 1);
      end
      last_id = int'(bus.rsp_id); last_data = bus.rsp_data; last_lat = lat;
      last_a_hi = a_hi; last_b_hi = b_hi; last_z_hi = z_hi;
      last_z_rises = z_rises; last_z_hs = z_hs_n; last_r_hi = r_hi;
    end
    @(posedge clk);
    #1;
    cyc++;
    a_cnt = (av && !a_hs) ? a_cnt + 1 : 0;
    b_cnt = (bv && !b_hs) ? b_cnt + 1 : 0;
    z_cnt = (zv && !z_hs) ? z_cnt + 1 : 0;
    r_cnt = (rv && !r_hs) ? r_cnt + 1 : 0;
    if (r_hs) begin m_busy = 0; n_rsp++; end
    if (gi >= 0) begin
      m_ptr = (gi + 1) % N; m_busy = 1;
      exp_id = gi; exp_a = opa[gi]; exp_b = opb[gi]; exp_sum = fadd(opa[gi], opb[gi]);
      g_cyc = cur;
      a_hi = 0; b_hi = 0; z_hi = 0; z_rises = 0; z_hs_n = 0; r_hi = 0;
      rsp_seen = 0; a_got = 0; b_got = 0;
      gnt_log.push_back(gi);
      if (rnd_dly) begin
        a_dly = $urandom_range(0, 3); b_dly = $urandom_range(0, 3);
        z_dly = $urandom_range(0, 4); r_dly = $urandom_range(0, 3);
      end
      if (cont) begin opa[gi] = rnd_op(); opb[gi] = rnd_op(); end
      else vld[gi] = 1'b0;
    end
    if (rnd_req)
      for (int i = 0; i < N; i++)
        if (!vld[i] && $urandom_range(0, 3) == 0) begin
          vld[i] = 1'b1; opa[i] = rnd_op(); opb[i] = rnd_op();
        end
  endtask

  task automatic run_rsp(input int n, input int budget);
    int target, c;
    target = n_rsp + n;
    c = 0;
    while (n_rsp < target && c < budget) begin step(); c++; end
    n_cmp++;
    if (n_rsp < target) begin
      n_err++;
      $display("FAIL rsp_timeout got %0d responses want %0d within %0d cycles", n_rsp - target + n, n, budget);
    end
  endtask

  task automatic set_mode(input int ad, input int bd, input int zd, input int rd, input bit c);
    a_dly = ad; b_dly = bd; z_dly = zd; r_dly = rd;
    cont = c; rnd_req = 0; rnd_dly = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    vld = '1;
    for (int i = 0; i < N; i++) begin opa[i] = rnd_op(); opb[i] = rnd_op(); end
    clear_model();
    bus.add_a_ack = 1'b1; bus.add_b_ack = 1'b1; bus.add_z_stb = 1'b1; bus.rsp_ready = 1'b1;
    bus.add_z = '1;
    bus.req_valid = vld;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
    n_cmp++;
    if ({bus.add_a_stb, bus.add_b_stb, bus.add_z_ack, bus.rsp_valid} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes got=%b want=0000", {bus.add_a_stb, bus.add_b_stb, bus.add_z_ack, bus.rsp_valid});
    end
    n_cmp++;
    if (bus.rsp_data !== '0 || bus.rsp_id !== '0) begin
      n_err++; $display("FAIL reset_rsp got id=%0d data=%h want 0", bus.rsp_id, bus.rsp_data);
    end
    n_cmp++;
    if (bus.add_a !== '0 || bus.add_b !== '0) begin
      n_err++; $display("FAIL reset_operands got a=%h b=%h want 0", bus.add_a, bus.add_b);
    end
  endtask

  task automatic test_single();
    set_mode(0, 0, 0, 0, 0);
    vld = '0;
    do_reset();
    vld[0] = 1'b1;
    opa[0] = $realtobits(1.0);
    opb[0] = $realtobits(0.1);
    run_rsp(1, 50);
    n_cmp++;
    if (last_id != 0 || last_data !== 64'h3FF199999999999A || last_lat != 3) begin
      n_err++;
      $display("FAIL single got id=%0d data=%h lat=%0d want id=0 data=3ff199999999999a lat=3",
               last_id, last_data, last_lat);
    end
  endtask

  task automatic test_round_robin();
    int want [5] = '{0, 1, 2, 3, 0};
    set_mode(0, 0, 0, 0, 1);
    vld = '1;
    for (int i = 0; i < N; i++) begin opa[i] = rnd_op(); opb[i] = rnd_op(); end
    do_reset();
    run_rsp(5, 100);
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if (gnt_log.size() <= k) begin
        n_err++; $display("FAIL rr_order[%0d] got none want %0d", k, want[k]);
      end else if (gnt_log[k] != want[k]) begin
        n_err++; $display("FAIL rr_order[%0d] got %0d want %0d", k, gnt_log[k], want[k]);
      end
    end
  endtask

  task automatic test_split_ack();
    set_mode(0, 3, 0, 0, 0);
    vld = '0;
    do_reset();
    vld[3] = 1'b1; opa[3] = rnd_op(); opb[3] = rnd_op();
    run_rsp(1, 60);
    n_cmp++;
    if (last_a_hi != 1 || last_b_hi != 4 || last_z_rises != 1) begin
      n_err++;
      $display("FAIL split_ack got a_stb=%0d b_stb=%0d wait_z_entries=%0d want 1 4 1", last_a_hi, last_b_hi, last_z_rises);
    end
  endtask

  task automatic test_rsp_backpressure();
    set_mode(0, 0, 0, 5, 1);
    vld = '1;
    for (int i = 0; i < N; i++) begin opa[i] = rnd_op(); opb[i] = rnd_op(); end
    do_reset();
    run_rsp(2, 80);
    n_cmp++;
    if (last_r_hi != 6 || last_id != 1) begin
      n_err++; $display("FAIL rsp_hold got valid_cycles=%0d id=%0d want 6 id=1", last_r_hi, last_id);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    set_mode(0, 0, 20, 0, 0);
    vld = '0;
    do_reset();
    vld[1] = 1'b1; opa[1] = rnd_op(); opb[1] = rnd_op();
    c = 0;
    while (bus.add_z_ack !== 1'b1 && c < 20) begin step(); c++; end
    n_cmp++;
    if (bus.add_z_ack !== 1'b1) begin n_err++; $display("FAIL wait_z_entry got z_ack=%b want 1", bus.add_z_ack); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({bus.add_a_stb, bus.add_b_stb, bus.add_z_ack, bus.rsp_valid} !== 4'b0000 || bus.req_ready !== '0 ||
        bus.add_a !== '0 || bus.add_b !== '0 || bus.rsp_data !== '0 || bus.rsp_id !== '0) begin
      n_err++;
      $display("FAIL async_reset got stb/ack/valid=%b ready=%b a=%h b=%h data=%h id=%0d want all 0",
               {bus.add_a_stb, bus.add_b_stb, bus.add_z_ack, bus.rsp_valid}, bus.req_ready,
               bus.add_a, bus.add_b, bus.rsp_data, bus.rsp_id);
    end
    set_mode(0, 0, 0, 0, 0);
    vld = '0;
    vld[2] = 1'b1; opa[2] = $realtobits(2.5); opb[2] = $realtobits(5.2);
    do_reset();
    run_rsp(1, 50);
    n_cmp++;
    if (last_id != 2 || last_data !== $realtobits(7.7) || gnt_log.size() != 1) begin
      n_err++;
      $display("FAIL post_reset got id=%0d data=%h grants=%0d want id=2 data=%h grants=1",
               last_id, last_data, gnt_log.size(), $realtobits(7.7));
    end
  endtask

  task automatic test_z_backpressure();
    set_mode(1, 0, 10, 0, 0);
    vld = '0;
    do_reset();
    vld[0] = 1'b1; opa[0] = rnd_op(); opb[0] = rnd_op();
    vld[1] = 1'b1; opa[1] = rnd_op(); opb[1] = rnd_op();
    run_rsp(2, 100);
    n_cmp++;
    if (last_z_hi != 11 || last_z_hs != 1 || last_id != 1) begin
      n_err++;
      $display("FAIL z_backpressure got z_ack_cycles=%0d captures=%0d id=%0d want 11 1 1", last_z_hi, last_z_hs, last_id);
    end
  endtask

  task automatic test_random();
    set_mode(0, 0, 0, 0, 0);
    vld = '0;
    do_reset();
    rnd_req = 1; rnd_dly = 1;
    for (int blk = 0; blk < 4; blk++) begin
      cont = ($urandom_range(0, 1) == 1);
      run_rsp(20, 1500);
    end
  endtask

  initial begin
    n_rsp = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_split_ack();
    test_rsp_backpressure();
    test_reset_mid();
    test_z_backpressure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fp_add_arbiter.md
FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4: number of requesters sharing one double_adder.
REQ-002 The block SHALL have parameter W, default 64: operand and result width (IEEE-754 double).
REQ-003 The block SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, NREQ: per-requester operand-pair valid.
REQ-006 The block SHALL have port req_a, input, NREQ*W: packed operand A, slice i belongs to requester i.
REQ-007 The block SHALL have port req_b, input, NREQ*W: packed operand B, slice i belongs to requester i.
REQ-008 The block SHALL have port req_ready, output, NREQ: one-hot accept pulse.
REQ-009 The block SHALL have ports add_a and add_b, output, W each: operands driven to double_adder.
REQ-010 The block SHALL have ports add_a_stb and add_b_stb, output, 1 each: operand strobes.
REQ-011 The block SHALL have ports add_a_ack and add_b_ack, input, 1 each: adder operand acks.
REQ-012 The block SHALL have port add_z, input, W: adder result.
REQ-013 The block SHALL have port add_z_stb, input, 1: adder result strobe.
REQ-014 The block SHALL have port add_z_ack, output, 1: result accept to adder.
REQ-015 The block SHALL have port rsp_valid, output, 1: result available.
REQ-016 The block SHALL have port rsp_id, output, clog2(NREQ): index of the originating requester.
REQ-017 The block SHALL have port rsp_data, output, W: registered sum.
REQ-018 The block SHALL have port rsp_ready, input, 1: consumer accepts the result.

Function
REQ-019 FSM states SHALL be IDLE, SEND, WAIT_Z and RESP; exactly one addition SHALL be in flight.
REQ-020 IDLE: if any req_valid, pick the first valid index at or after rr_ptr (wrapping modulo NREQ); pulse req_ready[i] combinationally that cycle; register req_a/req_b slice i and id i; go to SEND.
REQ-021 After each grant, rr_ptr SHALL become (i+1) mod NREQ; with no valid requests, rr_ptr and state SHALL hold.
REQ-022 SEND: a_stb and b_stb SHALL be set on entry; each SHALL clear independently the cycle after stb&ack is seen; the FSM SHALL go to WAIT_Z once both have transferred, including when acks arrive in different cycles or in the same cycle.
REQ-023 add_a and add_b SHALL hold the registered operands stable throughout SEND.
REQ-024 WAIT_Z: add_z_ack=1; on add_z_stb&add_z_ack, capture add_z into rsp_data, then go to RESP; add_z_ack SHALL be 0 in all other states.
REQ-025 RESP: rsp_valid=1 with stable rsp_id/rsp_data until rsp_ready; on rsp_valid&rsp_ready go to IDLE, and no grant SHALL occur in that same cycle.
REQ-026 req_valid changes outside IDLE SHALL be ignored; requesters hold valid until ready.
REQ-027 Minimum grant-to-response latency SHALL be 3 cycles: grant, SEND with same-cycle acks, then one WAIT_Z cycle with add_z_stb already high.
REQ-028 No arithmetic SHALL be done in this block; data SHALL pass bit-exact.

Reset
REQ-029 Reset SHALL act at any time, including mid-transaction: state=IDLE, rr_ptr=0, all stb/ack/valid outputs=0, req_ready=0, rsp_data=0, rsp_id=0, add_a=add_b=0.
REQ-030 The first grant after reset deassertion SHALL go to the lowest valid index.

Structure
REQ-031 A shared package fft_pkg SHALL hold NREQ, W, the FSM state enum and the id-width constant.
REQ-032 Round-robin selection SHALL be one sub-module, rr_arbiter (inputs req and ptr; outputs one-hot grant and index).

Verification
REQ-033 Single request: req0 a=1.0, b=0.1, adder acks immediately -> rsp_id=0, rsp_data=0x3FF199999999999A, grant-to-rsp_valid 3 cycles.
REQ-034 All four valid continuously from reset -> grant order 0,1,2,3,0; every rsp_id matches.
REQ-035 Split acks: a_ack at SEND+0, b_ack at SEND+3 -> a_stb drops after one cycle, b_stb stays 4 cycles, exactly one WAIT_Z entry.
REQ-036 rsp_ready held low 5 cycles -> rsp_valid/rsp_data stable; no req_ready pulse until accepted.
REQ-037 Reset asserted in WAIT_Z -> all outputs 0 asynchronously; after release, req2 alone is granted first with sum 2.5+5.2=7.7.
REQ-038 Back-pressure from adder: z_stb late 10 cycles -> add_z_ack high throughout; sum captured once.
